// File: rtl/md_unit_ctrl.sv
// HI/LO multiply/divide controller: computes MULT/DIV results at issue, then holds
// them back for a fixed latency while requesting D-stage stalls from the hazard unit.
module md_unit_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        md_use_D,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [31:0]    pend_hi, pend_lo;

    logic           is_md, is_div, is_signed;
    logic [63:0]    ext_a, ext_b, prod;
    logic           a_neg, b_neg;
    logic [31:0]    a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;
    logic [31:0]    res_hi, res_lo;
    logic [CW-1:0]  lat;

    assign is_md     = ~md_op[2];
    assign is_div    = md_op[1];
    assign is_signed = ~md_op[0];

    // Sign-extending for signed ops lets one 64x64 multiplier serve both MULT and MULTU.
    assign ext_a = {{32{is_signed & src_a[31]}}, src_a};
    assign ext_b = {{32{is_signed & src_b[31]}}, src_b};
    assign prod  = ext_a * ext_b;

    // Signed divide via magnitudes: quotient truncates toward zero, remainder takes
    // the dividend's sign. 0x80000000 / -1 falls out naturally as 0x80000000 rem 0.
    assign a_neg  = is_signed & src_a[31];
    assign b_neg  = is_signed & src_b[31];
    assign a_mag  = a_neg ? -src_a : src_a;
    assign b_mag  = b_neg ? -src_b : src_b;
    assign b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
    assign q_mag  = a_mag / b_safe;
    assign r_mag  = a_mag % b_safe;
    assign quot   = (a_neg ^ b_neg) ? -q_mag : q_mag;
    assign rem    = a_neg ? -r_mag : r_mag;

    always_comb begin
        res_hi = prod[63:32];
        res_lo = prod[31:0];
        if (is_div) begin
            if (src_b == 32'd0) begin
                res_hi = src_a;
                res_lo = 32'hFFFF_FFFF;
            end else begin
                res_hi = rem;
                res_lo = quot;
            end
        end
    end

    assign lat      = is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
    assign md_stall = md_use_D & (busy | (start & is_md));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            busy    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (is_md) begin
                            pend_hi <= res_hi;
                            pend_lo <= res_lo;
                            cnt     <= lat;
                            busy    <= 1'b1;
                            state   <= BUSY;
                        end else if (md_op == 3'd4) begin
                            hi <= src_a;
                        end else if (md_op == 3'd5) begin
                            lo <= src_a;
                        end
                    end
                end
                BUSY: begin
                    // Starts arriving here are protocol violations and are dropped.
                    if (cnt == CW'(1)) begin
                        hi    <= pend_hi;
                        lo    <= pend_lo;
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
